// File: rtl/main_mem_responder.sv
// Line-wide main-memory responder: accepts one read/write-back request, holds it for LATENCY
// cycles, then pulses done_mem. Optional MAIN_MEM_PARITY_EN adds per-line parity and parity_err.
module main_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LINE_W  = 64,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enable,
    input  logic              rd_wrt_mem,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] wr_data,
    output logic              done_mem,
    output logic [LINE_W-1:0] rd_data,
`ifdef MAIN_MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              mem_busy
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_rd_q, req_rd_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [LINE_W-1:0] req_data_q, req_data_d;
    logic              access;

    logic [LINE_W-1:0] mem [2**ADDR_W];
`ifdef MAIN_MEM_PARITY_EN
    logic              par_mem [2**ADDR_W];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_rd_d   = req_rd_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        access     = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_enable) begin
                    req_rd_d   = rd_wrt_mem;
                    req_addr_d = mem_addr;
                    req_data_d = wr_data;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: state_d = StIdle;
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            done_mem   <= 1'b0;
            mem_busy   <= 1'b0;
            rd_data    <= '0;
            req_rd_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
`ifdef MAIN_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_mem   <= (state_d == StDone);
            mem_busy   <= (state_d != StIdle);
            req_rd_q   <= req_rd_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            if (access && req_rd_q) begin
                rd_data <= mem[req_addr_q];
            end
`ifdef MAIN_MEM_PARITY_EN
            parity_err <= access && req_rd_q && (par_mem[req_addr_q] != ^mem[req_addr_q]);
`endif
        end
    end

    // Storage is never reset; a reset edge suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!rst && access && !req_rd_q) begin
            mem[req_addr_q] <= req_data_q;
`ifdef MAIN_MEM_PARITY_EN
            par_mem[req_addr_q] <= ^req_data_q;
`endif
        end
    end

endmodule
